trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Sequences machine-mode trap entry and MRET return around the CSR file. Owns the single CSR write port:
//  arbitrates WB-stage CSR-instruction writes against the multi-cycle trap-entry writes (MEPC, MCAUSE, MTVAL).
//  Drives pipeline flush/stall and the fetch redirect (to MTVEC on trap, to MEPC on MRET). Sits between WB and csrfile.
// PARAMETERS
//  IRQ_CAUSE    31'd11  mcause code used for a taken external interrupt (TRAP_CTRL_IRQ_EN only)
//  SYNC_STAGES  2       irq_i synchronizer depth, >=2 (TRAP_CTRL_IRQ_EN only)
// PORTS
//  clk_i            in   1   clock; single clock domain
//  rst_ni           in   1   reset, asynchronous assert, active-low
//  wb_valid_i       in   1   instruction valid in WB
//  wb_pc_i          in   32  PC of WB instruction
//  wb_trap_i        in   trap_info_t  synchronous trap info from WB (valid, pc, mcause, is_interrupt)
//  wb_tval_i        in   32  trap value for wb_trap_i
//  wb_is_mret_i     in   1   WB instruction is MRET
//  wb_csr_we_i      in   1   WB CSR instruction writes a CSR
//  wb_csr_waddr_i   in   12  CSR address from WB
//  wb_csr_wdata_i   in   32  CSR write data from WB
//  mtvec_i          in   32  current MTVEC from csrfile
//  mepc_i           in   32  current MEPC from csrfile
//  csr_we_o         out  1   CSR write strobe to csrfile
//  csr_waddr_o      out  12  CSR write address
//  csr_wdata_o      out  32  CSR write data
//  flush_o          out  1   kill IF..MEM
//  stall_o          out  1   hold IF/ID while sequencing
//  redirect_valid_o out  1   one-cycle fetch redirect strobe
//  redirect_pc_o    out  32  redirect target
//  retire_cancel_o  out  1   WB instruction not retired (trap/irq); gates minstret
//  double_trap_o    out  1   sticky: trap/mret arrived while not IDLE
//  irq_i            in   1   async external interrupt (TRAP_CTRL_IRQ_EN only)
//  irq_ack_o        out  1   pulse on irq redirect (TRAP_CTRL_IRQ_EN only)
// BEHAVIOUR
//  Reset: state IDLE; every output 0; latched pc/cause/tval 0; double_trap_o 0; irq pending 0.
//  FSM: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, REDIRECT, MRET_REDIRECT.
//  IDLE: csr_we_o = wb_valid_i & wb_csr_we_i & ~take; csr_waddr_o/csr_wdata_o pass through WB (0 when we=0).
//  Trap accept (cycle T): IDLE & wb_valid_i & wb_trap_i.valid -> flush_o=1, retire_cancel_o=1 at T; WB CSR write suppressed;
//   latch pc, {is_interrupt,mcause}, tval; -> SAVE_EPC.
//  T+1 SAVE_EPC: we=1 addr=MEPC data=pc. T+2 SAVE_CAUSE: addr=MCAUSE. T+3 SAVE_TVAL: addr=MTVAL.
//  T+4 REDIRECT: redirect_valid_o=1, redirect_pc_o={mtvec_i[31:2],2'b00}; -> IDLE. Trap latency: T -> redirect = 4 cycles.
//  MRET: IDLE & wb_valid_i & wb_is_mret_i & ~trap -> flush_o=1 at T; T+1 MRET_REDIRECT: redirect_pc_o=mepc_i -> IDLE.
//  Priority in IDLE: trap > irq > mret > CSR write. stall_o=1 in every non-IDLE state; flush_o only at accept cycle.
//  mtvec_i/mepc_i sampled in the redirect cycle, so a CSR write retired just before the trap/MRET is seen.
//  Non-IDLE: wb_valid_i ignored; any trap/mret seen sets double_trap_o (cleared only by reset).
//  Async reset mid-sequence: immediate IDLE, partial CSR writes not completed, no redirect.
// CONFIGURATION
//  TRAP_CTRL_IRQ_EN defined: irq_i passes SYNC_STAGES flops, sets sticky pending; taken in IDLE at next wb_valid_i with
//   no synchronous trap: that instruction squashed (retire_cancel_o=1), pc=wb_pc_i, cause={1'b1,IRQ_CAUSE}, tval=0,
//   same SAVE_* sequence; irq_ack_o pulses with redirect, pending cleared then.
//  Undefined: irq_i, irq_ack_o ports and all irq logic absent; IDLE ignores interrupts.
// STRUCTURE
//  params_pkg: trap_info_t (existing), CSR_ADDR_MEPC/MCAUSE/MTVAL, trap_ctrl_state_e enum.
//  Sub-module: irq_sync (SYNC_STAGES-flop synchronizer, rst_ni async clear), instantiated only under TRAP_CTRL_IRQ_EN.
// TESTING
//  1 WB csrrw mscratch=0xDEAD_BEEF, no trap -> same cycle csr_we_o=1, addr=0x340, data=0xDEADBEEF, no flush.
//  2 Trap pc=0x100 mcause=2 tval=0x13, mtvec_i=0x8000_0003 -> flush T; MEPC=0x100 @T+1, MCAUSE=2 @T+2,
//     MTVAL=0x13 @T+3; redirect 0x8000_0000 @T+4; stall_o high T+1..T+4.
//  3 MRET with mepc_i=0x204 -> flush T, redirect_pc_o=0x204 @T+1, no CSR writes.
//  4 Trap and CSR write same WB cycle -> CSR write suppressed; only MEPC/MCAUSE/MTVAL writes occur.
//  5 rst_ni low during SAVE_CAUSE -> outputs 0 immediately, no redirect, IDLE after release.
//  6 IRQ_EN: irq_i rises, next WB pc=0x40 -> MCAUSE=0x8000_000B, MEPC=0x40, irq_ack_o with redirect.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared types for the machine-mode trap sequencer.
// Trap info bundle, CSR addresses and FSM encoding.
package trap_ctrl_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [30:0] mcause;
    logic        is_interrupt;
  } trap_info_t;

  localparam logic [11:0] CSR_ADDR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL  = 12'h343;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_EPC,
    ST_SAVE_CAUSE,
    ST_SAVE_TVAL,
    ST_REDIRECT,
    ST_MRET_REDIRECT
  } trap_ctrl_state_e;

  function automatic logic [31:0] vec_base(
    input logic [31:0] v
  );
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchronizer for the asynchronous external interrupt.
// Asynchronously cleared by rst_ni; SYNC_STAGES must be >= 2.
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry / MRET sequencer owning the single CSR write port.
// Optional external interrupt support under TRAP_CTRL_IRQ_EN.
module trap_ctrl
  import trap_ctrl_pkg::*;
`ifdef TRAP_CTRL_IRQ_EN
#(
  parameter logic [30:0] IRQ_CAUSE   = 31'd11,
  parameter int unsigned SYNC_STAGES = 2
)
`endif
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_valid_i,
  input  logic [31:0] wb_pc_i,
  input  trap_info_t  wb_trap_i,
  input  logic [31:0] wb_tval_i,
  input  logic        wb_is_mret_i,
  input  logic        wb_csr_we_i,
  input  logic [11:0] wb_csr_waddr_i,
  input  logic [31:0] wb_csr_wdata_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        retire_cancel_o,
  output logic        double_trap_o
`ifdef TRAP_CTRL_IRQ_EN
  ,
  input  logic        irq_i,
  output logic        irq_ack_o
`endif
);

  trap_ctrl_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] tval_q, tval_d;
  logic        dbl_q, dbl_d;

  logic is_idle;
  logic trap_take;
  logic irq_take;
  logic mret_take;
  logic take;
  logic busy_hit;

`ifdef TRAP_CTRL_IRQ_EN
  logic irq_s;
  logic irq_prev_q;
  logic irq_pend_q, irq_pend_d;
  logic irq_seq_q, irq_seq_d;

  logic unused_ok;
  assign unused_ok = ^mtvec_i[1:0];

  irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (irq_i),
    .q_o   (irq_s)
  );
`else
  logic unused_ok;
  assign unused_ok = ^{wb_pc_i, mtvec_i[1:0]};
`endif

  // Take decisions; trap beats irq beats mret.
  always_comb begin
    is_idle   = (state_q == ST_IDLE);
    trap_take = is_idle & wb_valid_i & wb_trap_i.valid;
`ifdef TRAP_CTRL_IRQ_EN
    irq_take  = is_idle & wb_valid_i & ~wb_trap_i.valid & irq_pend_q;
`else
    irq_take  = 1'b0;
`endif
    take      = trap_take | irq_take;
    mret_take = is_idle & wb_valid_i & wb_is_mret_i & ~take;
    busy_hit  = ~is_idle & wb_valid_i
              & (wb_trap_i.valid | wb_is_mret_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_SAVE_EPC;
        end else if (mret_take) begin
          state_d = ST_MRET_REDIRECT;
        end
      end
      ST_SAVE_EPC:      state_d = ST_SAVE_CAUSE;
      ST_SAVE_CAUSE:    state_d = ST_SAVE_TVAL;
      ST_SAVE_TVAL:     state_d = ST_REDIRECT;
      ST_REDIRECT:      state_d = ST_IDLE;
      ST_MRET_REDIRECT: state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    dbl_d   = dbl_q | busy_hit;
    if (trap_take) begin
      pc_d    = wb_trap_i.pc;
      cause_d = {wb_trap_i.is_interrupt, wb_trap_i.mcause};
      tval_d  = wb_tval_i;
    end
`ifdef TRAP_CTRL_IRQ_EN
    else if (irq_take) begin
      pc_d    = wb_pc_i;
      cause_d = {1'b1, IRQ_CAUSE};
      tval_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      dbl_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      dbl_q   <= dbl_d;
    end
  end

  assign double_trap_o = dbl_q;

`ifdef TRAP_CTRL_IRQ_EN
  // Pending is set on a synchronized rising edge, cleared by the ack.
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (irq_ack_o) begin
      irq_pend_d = 1'b0;
    end
    if (irq_s & ~irq_prev_q) begin
      irq_pend_d = 1'b1;
    end
    irq_seq_d = irq_seq_q;
    if (take) begin
      irq_seq_d = irq_take;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_prev_q <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_seq_q  <= 1'b0;
    end else begin
      irq_prev_q <= irq_s;
      irq_pend_q <= irq_pend_d;
      irq_seq_q  <= irq_seq_d;
    end
  end

  assign irq_ack_o = (state_q == ST_REDIRECT) & irq_seq_q;
`endif

  // Redirect targets are read live so a just-retired CSR write is seen.
  always_comb begin
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    flush_o          = 1'b0;
    stall_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    retire_cancel_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        flush_o         = take | mret_take;
        retire_cancel_o = take;
        if (wb_valid_i & wb_csr_we_i & ~take) begin
          csr_we_o    = 1'b1;
          csr_waddr_o = wb_csr_waddr_i;
          csr_wdata_o = wb_csr_wdata_i;
        end
      end
      ST_SAVE_EPC: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_MEPC;
        csr_wdata_o = pc_q;
      end
      ST_SAVE_CAUSE: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      ST_SAVE_TVAL: begin
        stall_o     = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_MTVAL;
        csr_wdata_o = tval_q;
      end
      ST_REDIRECT: begin
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = vec_base(mtvec_i);
      end
      ST_MRET_REDIRECT: begin
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = mepc_i;
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: script-based model plus literal checks.
// Covers the IRQ path when TRAP_CTRL_IRQ_EN is defined.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  localparam int SYNC = 2;
  localparam logic [30:0] IRQC = 31'd11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid;
  logic [31:0] wb_pc;
  trap_info_t  wb_trap;
  logic [31:0] wb_tval;
  logic        wb_mret;
  logic        csr_we;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        flush_o, stall_o, rv_o, cancel_o, dbl_o;
  logic [31:0] rpc_o;
  logic        irq;
  logic        ack_o;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .wb_valid_i      (wb_valid),
    .wb_pc_i         (wb_pc),
    .wb_trap_i       (wb_trap),
    .wb_tval_i       (wb_tval),
    .wb_is_mret_i    (wb_mret),
    .wb_csr_we_i     (csr_we),
    .wb_csr_waddr_i  (waddr),
    .wb_csr_wdata_i  (wdata),
    .mtvec_i         (mtvec),
    .mepc_i          (mepc),
    .csr_we_o        (csr_we_o),
    .csr_waddr_o     (csr_waddr_o),
    .csr_wdata_o     (csr_wdata_o),
    .flush_o         (flush_o),
    .stall_o         (stall_o),
    .redirect_valid_o(rv_o),
    .redirect_pc_o   (rpc_o),
    .retire_cancel_o (cancel_o),
    .double_trap_o   (dbl_o)
`ifdef TRAP_CTRL_IRQ_EN
    ,
    .irq_i           (irq),
    .irq_ack_o       (ack_o)
`endif
  );

`ifndef TRAP_CTRL_IRQ_EN
  assign ack_o = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One scripted output cycle; tgt 1 = aligned mtvec, 2 = mepc.
  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [31:0] data;
    bit          flush;
    bit          stall;
    bit          rv;
    int          tgt;
    bit          cancel;
    bit          ack;
  } exp_t;

  function automatic exp_t mk(bit we, logic [11:0] a, logic [31:0] d,
                              bit rv, int tgt, bit ack);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.flush = 0; e.stall = 1;
    e.rv = rv; e.tgt = tgt; e.cancel = 0; e.ack = ack;
    return e;
  endfunction

  exp_t q[$];
  bit   m_dbl = 0;
  int   cyc = 0;
  int   irq_rise = -1;
  bit   irq_prev = 0;

  always @(negedge clk) begin
    exp_t e;
    bit idle, trp, irqt, take, mret, pend, dbl_n;
    logic [31:0] pc, cause, tv, rpc;
    cyc++;
    e = mk(0, 0, 0, 0, 0, 0);
    e.stall = 0;
    dbl_n = m_dbl;
    if (!rst_n) begin
      q.delete();
      m_dbl = 0;
      dbl_n = 0;
      irq_rise = -1;
    end else begin
      idle = (q.size() == 0);
      pend = (irq_rise >= 0) && (cyc >= irq_rise + SYNC + 1);
      if (!idle) begin
        e = q.pop_front();
        if (wb_valid && (wb_trap.valid || wb_mret)) dbl_n = 1;
      end else begin
        trp = wb_valid && wb_trap.valid;
`ifdef TRAP_CTRL_IRQ_EN
        irqt = wb_valid && !wb_trap.valid && pend;
`else
        irqt = 0;
`endif
        take = trp || irqt;
        mret = wb_valid && wb_mret && !take;
        if (take) begin
          pc    = trp ? wb_trap.pc : wb_pc;
          cause = trp ? {wb_trap.is_interrupt, wb_trap.mcause}
                      : {1'b1, IRQC};
          tv    = trp ? wb_tval : 32'h0;
          q.push_back(mk(1, 12'h341, pc, 0, 0, 0));
          q.push_back(mk(1, 12'h342, cause, 0, 0, 0));
          q.push_back(mk(1, 12'h343, tv, 0, 0, 0));
          q.push_back(mk(0, 0, 0, 1, 1, irqt));
        end else if (mret) begin
          q.push_back(mk(0, 0, 0, 1, 2, 0));
        end
        e.flush  = take || mret;
        e.cancel = take;
        if (wb_valid && csr_we && !take) begin
          e.we = 1; e.addr = waddr; e.data = wdata;
        end
      end
    end
    rpc = (e.tgt == 1) ? (mtvec & 32'hFFFF_FFFC) :
          (e.tgt == 2) ? mepc : 32'h0;
    chk("m_we", {31'd0, csr_we_o}, {31'd0, e.we});
    chk("m_waddr", {20'd0, csr_waddr_o}, {20'd0, e.addr});
    chk("m_wdata", csr_wdata_o, e.data);
    chk("m_flush", {31'd0, flush_o}, {31'd0, e.flush});
    chk("m_stall", {31'd0, stall_o}, {31'd0, e.stall});
    chk("m_rv", {31'd0, rv_o}, {31'd0, e.rv});
    chk("m_rpc", rpc_o, rpc);
    chk("m_cancel", {31'd0, cancel_o}, {31'd0, e.cancel});
    chk("m_dbl", {31'd0, dbl_o}, {31'd0, m_dbl});
    chk("m_ack", {31'd0, ack_o}, {31'd0, e.ack});
    if (rst_n && e.ack) irq_rise = -1;
    if (rst_n && irq && !irq_prev) irq_rise = cyc;
    irq_prev = irq;
    m_dbl = dbl_n;
  end

  task automatic idle_in();
    wb_valid = 0; wb_pc = 0; wb_trap = '0; wb_tval = 0;
    wb_mret = 0; csr_we = 0; waddr = 0; wdata = 0;
  endtask

  task automatic drv_trap(input logic [31:0] pc, input logic [30:0] c,
                          input logic [31:0] tv);
    wb_valid = 1; wb_pc = pc; wb_tval = tv;
    wb_trap.valid = 1; wb_trap.pc = pc;
    wb_trap.mcause = c; wb_trap.is_interrupt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_in();
    irq = 0; mtvec = 0; mepc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", {31'd0, csr_we_o}, 0);
    chk("rst_stall", {31'd0, stall_o}, 0);
    chk("rst_dbl", {31'd0, dbl_o}, 0);
    step(); rst_n = 1;

    // csrrw mscratch
    step();
    wb_valid = 1; csr_we = 1; waddr = 12'h340; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_we", {31'd0, csr_we_o}, 1);
    chk("t1_addr", {20'd0, csr_waddr_o}, 32'h340);
    chk("t1_data", csr_wdata_o, 32'hDEAD_BEEF);
    chk("t1_flush", {31'd0, flush_o}, 0);
    step(); idle_in();

    // basic trap
    mtvec = 32'h8000_0003;
    step(); drv_trap(32'h100, 31'd2, 32'h13);
    @(negedge clk);
    chk("t2_flush", {31'd0, flush_o}, 1);
    chk("t2_cancel", {31'd0, cancel_o}, 1);
    step(); idle_in();
    @(negedge clk);
    chk("t2_epc_a", {20'd0, csr_waddr_o}, 32'h341);
    chk("t2_epc_d", csr_wdata_o, 32'h100);
    chk("t2_stall1", {31'd0, stall_o}, 1);
    @(negedge clk);
    chk("t2_cause", csr_wdata_o, 32'h2);
    @(negedge clk);
    chk("t2_tval", csr_wdata_o, 32'h13);
    @(negedge clk);
    chk("t2_rv", {31'd0, rv_o}, 1);
    chk("t2_rpc", rpc_o, 32'h8000_0000);
    chk("t2_stall4", {31'd0, stall_o}, 1);
    @(negedge clk);
    chk("t2_done", {31'd0, stall_o}, 0);

    // mret
    mepc = 32'h204;
    step(); wb_valid = 1; wb_mret = 1;
    @(negedge clk);
    chk("t3_flush", {31'd0, flush_o}, 1);
    chk("t3_we", {31'd0, csr_we_o}, 0);
    step(); idle_in();
    @(negedge clk);
    chk("t3_rpc", rpc_o, 32'h204);
    chk("t3_we1", {31'd0, csr_we_o}, 0);

    // trap + CSR write together; traffic during sequence ignored
    step();
    drv_trap(32'h300, 31'd5, 32'h0);
    csr_we = 1; waddr = 12'h340; wdata = 32'h1234;
    @(negedge clk);
    chk("t4_sup", {31'd0, csr_we_o}, 0);
    step(); idle_in();
    wb_valid = 1; csr_we = 1; waddr = 12'h305; wdata = 32'h55;
    @(negedge clk);
    chk("t4_epc_a", {20'd0, csr_waddr_o}, 32'h341);
    step(); idle_in(); wb_valid = 1; wb_mret = 1;
    step(); idle_in();
    repeat (3) @(negedge clk);
    chk("t4_dbl", {31'd0, dbl_o}, 1);

    // trap beats mret in the same cycle
    step(); drv_trap(32'h400, 31'd7, 32'h77); wb_mret = 1;
    @(negedge clk);
    chk("pri_cancel", {31'd0, cancel_o}, 1);
    step(); idle_in();
    @(negedge clk);
    chk("pri_epc", csr_wdata_o, 32'h400);
    repeat (4) @(negedge clk);

    // async reset during SAVE_CAUSE
    step(); drv_trap(32'h500, 31'd3, 32'h9);
    step(); idle_in();
    step();
    chk("t5_cause_a", {20'd0, csr_waddr_o}, 32'h342);
    #1 rst_n = 0;
    #1;
    chk("t5_we", {31'd0, csr_we_o}, 0);
    chk("t5_stall", {31'd0, stall_o}, 0);
    chk("t5_dbl", {31'd0, dbl_o}, 0);
    step(); rst_n = 1;
    repeat (5) @(negedge clk);
    chk("t5_idle", {31'd0, stall_o}, 0);
    chk("t5_norv", {31'd0, rv_o}, 0);

`ifdef TRAP_CTRL_IRQ_EN
    step(); irq = 1;
    repeat (4) @(posedge clk);
    #1; wb_valid = 1; wb_pc = 32'h40;
    @(negedge clk);
    chk("t6_cancel", {31'd0, cancel_o}, 1);
    step(); idle_in(); irq = 0;
    @(negedge clk);
    chk("t6_epc", csr_wdata_o, 32'h40);
    @(negedge clk);
    chk("t6_cause", csr_wdata_o, 32'h8000_000B);
    @(negedge clk);
    chk("t6_tval", csr_wdata_o, 32'h0);
    @(negedge clk);
    chk("t6_ack", {31'd0, ack_o}, 1);
    chk("t6_rv", {31'd0, rv_o}, 1);
    repeat (3) @(negedge clk);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
